// File: rtl/stream_buffer_fifo.sv
// Valid/ready stream FIFO (DEPTH x WIDTH) with flush and occupancy; STREAM_BUFFER_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle from write to OUT_VALID (0 cycles through the bypass when enabled).
// Backpressure: IN_READY = !FULL, independent of OUT_READY; OUT_READY is ignored while empty.
module stream_buffer_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] IN_D,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             wr_en;
  logic             rd_en;
  logic             bypass;

  assign FULL     = (count_q == CNT_W'(DEPTH));
  assign EMPTY    = (count_q == '0);
  assign COUNT    = count_q;
  assign IN_READY = !FULL;

`ifdef STREAM_BUFFER_BYPASS_EN
  // An empty queue hands the word straight through; it is never stored.
  assign bypass = EMPTY && IN_VALID && OUT_READY && !FLUSH && !RESET;
`else
  assign bypass = 1'b0;
`endif

  assign OUT_VALID = !EMPTY || bypass;

  always_comb begin
    OUT_D = '0;
    if (bypass)
      OUT_D = IN_D;
    else if (!EMPTY)
      OUT_D = mem[rd_ptr];
  end

  assign wr_en = IN_VALID && !FULL && !bypass;
  assign rd_en = OUT_READY && !EMPTY;

  always_ff @(posedge CLK) begin
    if (wr_en && !FLUSH)
      mem[wr_ptr] <= IN_D;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A refused word must be held steady by the producer.
  in_d_stable_a: assert property (@(posedge CLK) disable iff (RESET)
    (IN_VALID && !IN_READY) |=> (!IN_VALID || $stable(IN_D)));
  full_empty_a: assert property (@(posedge CLK) disable iff (RESET)
    !(FULL && EMPTY));
`endif

endmodule

// File: tb/tb_stream_buffer_fifo.sv
// Randomised and directed bench for stream_buffer_fifo against a queue-based reference model.
module tb_stream_buffer_fifo;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef STREAM_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_d;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_d;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  always #5 clk = ~clk;

  stream_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush),
    .IN_D(in_d), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_D(out_d), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .COUNT(count), .FULL(full), .EMPTY(empty)
  );

  logic [WIDTH-1:0] model_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  bit               stalled = 1'b0;
  logic [WIDTH-1:0] last_d  = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // Presents one cycle of inputs, checks outputs against the model, then advances one edge.
  task automatic cycle(input bit fl, input bit iv, input logic [WIDTH-1:0] id, input bit ordy);
    int               sz;
    bit               byp;
    logic [WIDTH-1:0] exp_d;
    flush     = fl;
    in_valid  = iv;
    in_d      = id;
    out_ready = ordy;
    #1;
    sz    = model_q.size();
    byp   = BYP && (sz == 0) && iv && ordy && !fl;
    exp_d = '0;
    if (sz != 0) exp_d = model_q[0];
    else if (byp) exp_d = id;
    check("count",     32'(count),     32'(sz));
    check("full",      32'(full),      32'(sz == DEPTH));
    check("empty",     32'(empty),     32'(sz == 0));
    check("in_ready",  32'(in_ready),  32'(sz != DEPTH));
    check("out_valid", 32'(out_valid), 32'((sz != 0) || byp));
    check("out_d",     32'(out_d),     32'(exp_d));
    @(posedge clk);
    stalled = iv && (sz == DEPTH);
    last_d  = id;
    if (fl) begin
      model_q.delete();
    end else begin
      if ((sz != 0) && ordy) void'(model_q.pop_front());
      if (iv && (sz != DEPTH) && !byp) model_q.push_back(id);
    end
    #1;
  endtask

  bit               r_iv;
  bit               r_ordy;
  bit               r_fl;
  logic [WIDTH-1:0] r_d;
  int               wr_bias;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_d = '0; out_ready = 1'b0;
    #2;
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_d",     32'(out_d),     32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Fill to full, refused fifth word, then drain in order.
    cycle(0, 1, 2'b01, 0);
    cycle(0, 1, 2'b10, 0);
    cycle(0, 1, 2'b11, 0);
    cycle(0, 1, 2'b00, 0);
    cycle(0, 1, 2'b11, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'b00, 1);
    cycle(0, 0, 2'b00, 0);

    // Steady concurrent streaming at occupancy 2 across pointer wraps.
    cycle(0, 1, 2'b10, 0);
    cycle(0, 1, 2'b01, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, WIDTH'($urandom), 1);
      check("wrap_count", 32'(count), 32'd2);
    end

    // Read at full with a refused write, then flush at occupancy 3.
    cycle(0, 1, 2'b11, 0);
    cycle(0, 1, 2'b00, 0);
    cycle(0, 1, 2'b01, 1);
    cycle(0, 0, 2'b01, 0);
    cycle(1, 1, 2'b10, 1);
    cycle(0, 0, 2'b00, 0);

    // Empty-queue handoff: same-cycle with bypass, next cycle without.
    cycle(0, 1, 2'b10, 1);
    cycle(0, 0, 2'b00, 1);
    cycle(0, 0, 2'b00, 0);

    // Asynchronous reset in mid-cycle with three words stored.
    cycle(0, 1, 2'b01, 0);
    cycle(0, 1, 2'b10, 0);
    cycle(0, 1, 2'b11, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_count",     32'(count),     32'd0);
    check("mid_rst_empty",     32'(empty),     32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_d",     32'(out_d),     32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    model_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    stalled = 1'b0;

    // Random traffic: write-heavy, then read-heavy, then balanced.
    for (int i = 0; i < 600; i++) begin
      wr_bias = (i < 200) ? 80 : (i < 400) ? 25 : 55;
      r_iv    = ($urandom_range(0, 99) < wr_bias);
      r_ordy  = ($urandom_range(0, 99) >= wr_bias - 10);
      r_fl    = ($urandom_range(0, 63) == 0);
      r_d     = WIDTH'($urandom);
      if (stalled && r_iv) r_d = last_d;
      cycle(r_fl, r_iv, r_d, r_ordy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_buffer_fifo.md
Name: stream_buffer_fifo

Overview:
- Parametrised, handshaked successor to the plain 2-bit pass-through buffer.
- Decouples the DLX datapath from the image-sharpening extension pixel/coefficient streams.
- Stores up to DEPTH words of WIDTH bits, with valid/ready flow control on both sides, a synchronous flush, and an occupancy count.
- Sits between the DLX memory-read path and the sharpening kernel, and between kernel and write-back.

Parameters:
WIDTH, 2, data word width in bits (>=1)
DEPTH, 4, storage entries; power of two, >=2
CNT_W, $clog2(DEPTH)+1, width of COUNT; derived, not overridden

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
FLUSH  in  1  synchronous clear of contents
IN_D  in  WIDTH  write data
IN_VALID  in  1  producer presents IN_D
IN_READY  out  1  buffer accepts a word this cycle
OUT_D  out  WIDTH  head-of-queue data
OUT_VALID  out  1  OUT_D holds a stored word
OUT_READY  in  1  consumer takes OUT_D this cycle
COUNT  out  CNT_W  number of stored words, 0..DEPTH
FULL  out  1  COUNT==DEPTH
EMPTY  out  1  COUNT==0

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RESET).
- Reset values:
  - write and read pointers = 0; COUNT = 0.
  - EMPTY = 1, FULL = 0, OUT_VALID = 0, IN_READY = 1.
  - OUT_D = 0; storage contents are don't-care.
- Write: occurs when IN_VALID && IN_READY at a rising edge.
  - IN_D is stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Read: occurs when OUT_VALID && OUT_READY at a rising edge; rd_ptr increments modulo DEPTH.
- IN_READY = !FULL (combinational from registered state). It does not depend on OUT_READY.
- OUT_VALID = !EMPTY. OUT_D = mem[rd_ptr], with a registered-state read and no combinational path from IN_D.
- Latency: a word written at edge N is visible on OUT_D/OUT_VALID after edge N (first-word latency 1 cycle). Words leave strictly in write order.
- COUNT update per edge:
  - +1 on write only; -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- Full boundary (COUNT==DEPTH):
  - IN_READY = 0; IN_VALID is ignored.
  - A read that cycle frees a slot; IN_READY rises the next cycle.
- Empty boundary (COUNT==0):
  - OUT_VALID = 0; OUT_READY is ignored.
  - A write that cycle makes OUT_VALID = 1 the next cycle.
- Simultaneous read and write when 0 < COUNT < DEPTH: both happen, COUNT holds.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. FULL and EMPTY are derived from COUNT, not from pointer compare.
- FLUSH (synchronous, highest priority over write and read):
  - Next edge: pointers = 0, COUNT = 0.
  - Any write or read presented that cycle is discarded.
- RESET asserted mid-transfer: state clears immediately (asynchronously). The in-flight word is lost. No handshake completes while RESET is high.
- Producer rule (verified by assertion): IN_D must be stable while IN_VALID=1 && IN_READY=0. The block itself does not depend on this rule.
- FULL and EMPTY are never both 1.

Optional Feature:
- Macro: STREAM_BUFFER_BYPASS_EN.
- Defined (bypass path):
  - When EMPTY && IN_VALID && OUT_READY, IN_D drives OUT_D combinationally and OUT_VALID = 1 in the same cycle.
  - The word is consumed without being stored; COUNT stays 0; zero-cycle latency.
  - In every other state, behaviour is identical to the undefined case.
  - FLUSH=1 suppresses the bypass (OUT_VALID = 0).
- Undefined: no combinational IN-to-OUT path; minimum latency is 1 cycle as above.

Test Plan:
- Reset check: assert RESET mid-cycle with COUNT=3 → immediately COUNT=0, EMPTY=1, OUT_VALID=0, OUT_D=0, IN_READY=1.
- Fill/drain, WIDTH=2, DEPTH=4, OUT_READY=0: write 2'b01, 2'b10, 2'b11, 2'b00 → FULL=1, IN_READY=0, COUNT=4. A 5th write of 2'b11 is ignored. Then OUT_READY=1 for 4 cycles → OUT_D sequence 01,10,11,00, then EMPTY=1.
- Wrap and concurrency: keep COUNT=2; stream 10 words with IN_VALID=OUT_READY=1 → COUNT stays 2 throughout, output order matches input, pointers wrap twice.
- Full + read same cycle: at COUNT=4, OUT_READY=1 and IN_VALID=1 → the read completes and the write is refused (IN_READY was 0). Next cycle COUNT=3, IN_READY=1.
- Flush priority: at COUNT=3, assert FLUSH with IN_VALID=1 and OUT_READY=1 → next edge COUNT=0, EMPTY=1, no word output or stored.
- Bypass, with STREAM_BUFFER_BYPASS_EN defined: EMPTY, IN_D=2'b10, IN_VALID=1, OUT_READY=1 → OUT_VALID=1 and OUT_D=2'b10 in the same cycle, COUNT stays 0. With the macro undefined, the word appears on OUT_D one cycle later.
